deal_sequencer: RTL and testbench

Sequences the card generator for one blackjack round. It arbitrates card requests from the game FSM (initial deal, player hit, dealer hit) and pulses the generator's `on` input. It then validates the returned cards and delivers them one per cycle, tagged with a player or dealer destination. It sits between the game-control FSM and the card generator, and is the only block that drives the generator's `on` and `test` inputs.

---
 rtl/deal_sequencer.sv | 177 +++++++++++++++++
 tb/tb_deal_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/deal_sequencer.sv
// Card-request sequencer between the blackjack game FSM and the card generator.
// Optional DEAL_HOLE_CARD_EN flags the dealer's second initial card on out_hidden.
module deal_sequencer #(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       hit_p_req,
    input  logic       hit_d_req,
    input  logic [2:0] test_sel,
    input  logic [3:0] card1_in,
    input  logic [3:0] card2_in,
    output logic       gen_on,
    output logic [2:0] gen_test,
    output logic       deal_ack,
    output logic       hit_p_ack,
    output logic       hit_d_ack,
    output logic       err,
    output logic       out_valid,
    output logic [3:0] out_card,
    output logic       out_dest,
    output logic       out_hidden,
    output logic       busy,
    output logic [5:0] dealt_cnt
);

    localparam int unsigned CARD_W  = 4;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned RETRY_W = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DLV0  = 3'd3;
    localparam logic [2:0] S_DLV1  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] JOB_DEAL  = 2'd0;
    localparam logic [1:0] JOB_HIT_P = 2'd1;
    localparam logic [1:0] JOB_HIT_D = 2'd2;

    logic [2:0]         state, state_next;
    logic [1:0]         job, job_next;
    logic               phase, phase_next;
    logic               abort, abort_next;
    logic [RETRY_W-1:0] retry_cnt, retry_next;
    logic [CARD_W-1:0]  card1, card1_next, card2, card2_next;
    logic [2:0]         test_next;
    logic               bad;

    logic               valid_next, dest_next, hidden_next;
    logic [CARD_W-1:0]  card_out_next;

    // Face-card codes 11..15 count as 10
    function automatic logic [CARD_W-1:0] clamp_card(input logic [CARD_W-1:0] c);
        return (c > CARD_W'(10)) ? CARD_W'(10) : c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        job_next   = job;
        phase_next = phase;
        abort_next = abort;
        retry_next = retry_cnt;
        card1_next = card1;
        card2_next = card2;
        test_next  = gen_test;
        bad        = 1'b0;
        case (state)
            S_IDLE: begin
                if (deal_req || hit_p_req || hit_d_req) begin
                    state_next = S_ISSUE;
                    phase_next = 1'b0;
                    abort_next = 1'b0;
                    retry_next = '0;
                    test_next  = test_sel;
                    if (deal_req)       job_next = JOB_DEAL;
                    else if (hit_p_req) job_next = JOB_HIT_P;
                    else                job_next = JOB_HIT_D;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                card1_next = clamp_card(card1_in);
                card2_next = clamp_card(card2_in);
                bad = (card1_in == '0) || ((job == JOB_DEAL) && (card2_in == '0));
                if (!bad) begin
                    state_next = S_DLV0;
                end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                    retry_next = retry_cnt + RETRY_W'(1);
                    state_next = S_ISSUE;
                end else begin
                    abort_next = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DLV0: state_next = (job == JOB_DEAL) ? S_DLV1 : S_DONE;
            S_DLV1: begin
                if (!phase) begin
                    phase_next = 1'b1;
                    retry_next = '0;
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output values for the upcoming state, so every output leaves a flop
    always_comb begin
        valid_next    = (state_next == S_DLV0) || (state_next == S_DLV1);
        dest_next     = (job_next == JOB_HIT_D) || ((job_next == JOB_DEAL) && phase_next);
        card_out_next = '0;
        if (state_next == S_DLV0)      card_out_next = card1_next;
        else if (state_next == S_DLV1) card_out_next = card2_next;
`ifdef DEAL_HOLE_CARD_EN
        hidden_next = (state_next == S_DLV1) && (job_next == JOB_DEAL) && phase_next;
`else
        hidden_next = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job        <= JOB_DEAL;
            phase      <= 1'b0;
            abort      <= 1'b0;
            retry_cnt  <= '0;
            card1      <= '0;
            card2      <= '0;
            gen_on     <= 1'b0;
            gen_test   <= '0;
            deal_ack   <= 1'b0;
            hit_p_ack  <= 1'b0;
            hit_d_ack  <= 1'b0;
            err        <= 1'b0;
            out_valid  <= 1'b0;
            out_card   <= '0;
            out_dest   <= 1'b0;
            out_hidden <= 1'b0;
            busy       <= 1'b0;
            dealt_cnt  <= '0;
        end else begin
            job        <= job_next;
            phase      <= phase_next;
            abort      <= abort_next;
            retry_cnt  <= retry_next;
            card1      <= card1_next;
            card2      <= card2_next;
            gen_test   <= test_next;
            gen_on     <= (state_next == S_ISSUE);
            deal_ack   <= (state_next == S_DONE) && (job_next == JOB_DEAL);
            hit_p_ack  <= (state_next == S_DONE) && (job_next == JOB_HIT_P);
            hit_d_ack  <= (state_next == S_DONE) && (job_next == JOB_HIT_D);
            err        <= (state_next == S_DONE) && abort_next;
            out_valid  <= valid_next;
            out_card   <= card_out_next;
            out_dest   <= valid_next && dest_next;
            out_hidden <= hidden_next;
            busy       <= (state_next != S_IDLE);
            if ((state == S_IDLE) && (state_next == S_ISSUE) && (job_next == JOB_DEAL))
                dealt_cnt <= '0;
            else if (out_valid && (dealt_cnt != {CNT_W{1'b1}}))
                dealt_cnt <= dealt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_deal_sequencer.sv
// Scoreboard bench for deal_sequencer: a generator model feeds queued card pairs,
// expected deliveries are queued with the stimulus and compared on out_valid.
module tb_deal_sequencer;

    typedef struct packed {
        logic [3:0] card;
        logic       dest;
        logic       hidden;
    } dlv_t;

`ifdef DEAL_HOLE_CARD_EN
    localparam logic HID = 1'b1;
`else
    localparam logic HID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       deal_req, hit_p_req, hit_d_req;
    logic [2:0] test_sel;
    logic [3:0] card1_in, card2_in;
    logic       gen_on;
    logic [2:0] gen_test;
    logic       deal_ack, hit_p_ack, hit_d_ack, err;
    logic       out_valid;
    logic [3:0] out_card;
    logic       out_dest, out_hidden, busy;
    logic [5:0] dealt_cnt;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   gen_cnt = 0;
    dlv_t eq[$];
    logic [7:0] gq[$];

    deal_sequencer #(.MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset),
        .deal_req(deal_req), .hit_p_req(hit_p_req), .hit_d_req(hit_d_req),
        .test_sel(test_sel), .card1_in(card1_in), .card2_in(card2_in),
        .gen_on(gen_on), .gen_test(gen_test),
        .deal_ack(deal_ack), .hit_p_ack(hit_p_ack), .hit_d_ack(hit_d_ack), .err(err),
        .out_valid(out_valid), .out_card(out_card), .out_dest(out_dest),
        .out_hidden(out_hidden), .busy(busy), .dealt_cnt(dealt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_gen(input logic [3:0] c1, input logic [3:0] c2);
        gq.push_back({c1, c2});
    endtask

    task automatic push_exp(input logic [3:0] card, input logic dest, input logic hidden);
        dlv_t e;
        e.card = card; e.dest = dest; e.hidden = hidden;
        eq.push_back(e);
    endtask

    // Generator model and delivery scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (gen_on) begin
                gen_cnt++;
                if (gq.size() > 0) {card1_in, card2_in} = gq.pop_front();
                else               {card1_in, card2_in} = 8'h00;
            end
            if (out_valid) begin
                if (eq.size() == 0) begin
                    check("dlv_unexpected", 0, 1);
                end else begin
                    dlv_t e;
                    e = eq.pop_front();
                    check("dlv_card", out_card, e.card);
                    check("dlv_dest", out_dest, e.dest);
                    check("dlv_hidden", out_hidden, e.hidden);
                end
            end
        end
    end

    task automatic set_reqs(input logic [2:0] m);
        {hit_d_req, hit_p_req, deal_req} = m;
    endtask

    // Waits for any ack; mask is the expected {hit_d,hit_p,deal} pattern
    task automatic wait_ack(input string tag, input logic [2:0] mask, input int t0,
                            input int exp_lat, input logic exp_err);
        bit got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ({hit_d_ack, hit_p_ack, deal_ack} != 3'b000) begin
                got = 1;
                check({tag, "_ack_kind"}, {hit_d_ack, hit_p_ack, deal_ack}, mask);
                check({tag, "_ack_lat"}, cyc - t0, exp_lat);
                check({tag, "_err"}, err, exp_err);
                break;
            end
        end
        check({tag, "_ack_seen"}, got, 1);
    endtask

    task automatic do_job(input string tag, input logic [2:0] mask, input int exp_lat,
                          input logic exp_err, input int exp_pulses);
        int g0, t0;
        @(negedge clk);
        g0 = gen_cnt;
        t0 = cyc;
        set_reqs(mask);
        wait_ack(tag, mask, t0, exp_lat, exp_err);
        set_reqs(3'b000);
        check({tag, "_pulses"}, gen_cnt - g0, exp_pulses);
        check({tag, "_queue_drained"}, eq.size(), 0);
    endtask

    initial begin
        int t0;
        bit seen;
        reset = 1'b1;
        set_reqs(3'b000);
        test_sel = 3'd0;
        card1_in = 4'd0;
        card2_in = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_gen_on", gen_on, 0);
        check("rst_valid", out_valid, 0);
        check("rst_dealt", dealt_cnt, 0);
        check("rst_acks", {hit_d_ack, hit_p_ack, deal_ack, err}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Initial deal, blackjack mode
        test_sel = 3'd2;
        push_gen(4'd10, 4'd1);  push_gen(4'd8, 4'd9);
        push_exp(4'd10, 1'b0, 1'b0); push_exp(4'd1, 1'b0, 1'b0);
        push_exp(4'd8, 1'b1, 1'b0);  push_exp(4'd9, 1'b1, HID);
        do_job("deal", 3'b001, 9, 1'b0, 2);
        check("deal_gen_test", gen_test, 2);
        @(negedge clk);
        check("deal_dealt_cnt", dealt_cnt, 4);
        check("deal_idle", busy, 0);

        // Player hit, simple mode; test_sel changes mid-service are ignored
        test_sel = 3'd1;
        push_gen(4'd4, 4'd0);
        push_exp(4'd4, 1'b0, 1'b0);
        fork
            do_job("hitp", 3'b010, 4, 1'b0, 1);
            begin
                repeat (2) @(negedge clk);
                test_sel = 3'd5;
                check("hitp_busy", busy, 1);
                check("hitp_gen_test_held", gen_test, 1);
            end
        join
        check("hitp_dealt_cnt", dealt_cnt, 5);

        // Zero card on the first pulse
        push_gen(4'd0, 4'd3);  push_gen(4'd7, 4'd3);
        push_exp(4'd7, 1'b0, 1'b0);
        do_job("zero", 3'b010, 6, 1'b0, 2);

        // Retries exhausted on a dealer hit
        for (int i = 0; i < 4; i++) push_gen(4'd0, 4'd5);
        do_job("exhaust", 3'b100, 9, 1'b1, 4);
        check("exhaust_dealt_cnt", dealt_cnt, 6);

        // Simultaneous player and dealer hits; face card clamps to 10
        push_gen(4'd3, 4'd0);  push_gen(4'd11, 4'd0);
        push_exp(4'd3, 1'b0, 1'b0); push_exp(4'd10, 1'b1, 1'b0);
        @(negedge clk);
        t0 = cyc;
        set_reqs(3'b110);
        wait_ack("simul_p", 3'b010, t0, 4, 1'b0);
        hit_p_req = 1'b0;
        t0 = cyc;
        wait_ack("simul_d", 3'b100, t0, 5, 1'b0);
        hit_d_req = 1'b0;

        // Deal with a zero card2 on the first player pulse, plus clamped card1
        push_gen(4'd5, 4'd0);  push_gen(4'd13, 4'd2);  push_gen(4'd6, 4'd7);
        push_exp(4'd10, 1'b0, 1'b0); push_exp(4'd2, 1'b0, 1'b0);
        push_exp(4'd6, 1'b1, 1'b0);  push_exp(4'd7, 1'b1, HID);
        do_job("deal_retry", 3'b001, 11, 1'b0, 3);

        // Reset during the player's second card
        push_gen(4'd9, 4'd2);  push_gen(4'd4, 4'd6);
        push_exp(4'd9, 1'b0, 1'b0); push_exp(4'd2, 1'b0, 1'b0);
        push_exp(4'd4, 1'b1, 1'b0); push_exp(4'd6, 1'b1, HID);
        @(negedge clk);
        deal_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_card == 4'd2) begin
                seen = 1;
                break;
            end
        end
        check("rstmid_reached_dlv1", seen, 1);
        #2 reset = 1'b1;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_card", out_card, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_dealt", dealt_cnt, 0);
        check("rstmid_gen_test", gen_test, 0);
        deal_req = 1'b0;
        gq.delete();
        eq.delete();
        @(negedge clk);
        reset = 1'b0;

        // Fresh deal after reset
        test_sel = 3'd3;
        push_gen(4'd2, 4'd3);  push_gen(4'd10, 4'd5);
        push_exp(4'd2, 1'b0, 1'b0);  push_exp(4'd3, 1'b0, 1'b0);
        push_exp(4'd10, 1'b1, 1'b0); push_exp(4'd5, 1'b1, HID);
        do_job("deal_after_rst", 3'b001, 9, 1'b0, 2);
        @(negedge clk);
        check("final_dealt_cnt", dealt_cnt, 4);
        check("final_gen_test", gen_test, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
